// File: rtl/asic_iocut_pkg.sv
// Shared types and helpers for the padring supply-cut sequencer.
package asic_iocut_pkg;

    typedef enum logic [2:0] {
        OFF   = 3'd0,
        UP    = 3'd1,
        ON    = 3'd2,
        DOWN  = 3'd3,
        FAULT = 3'd4
    } state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned NSEG_DEFAULT = 4;
    localparam int unsigned IDXW_DEFAULT = clog2_min1(NSEG_DEFAULT);

endpackage

// File: rtl/asic_iocut_timer.sv
// Loadable saturating down-counter; zero is high while the count is 0.
module asic_iocut_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/asic_iocut_seq.sv
// Padring supply-cut sequencer: staggered segment enables with ack handshake.
// Optional ack-wait timeout enabled by defining ASIC_IOCUT_SEQ_TIMEOUT_EN.
module asic_iocut_seq
    import asic_iocut_pkg::*;
#(
    parameter int unsigned NSEG  = 4,
    parameter int unsigned NCTRL = 8,
    parameter int unsigned DLYW  = 8,
    parameter int unsigned TMO   = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DLYW-1:0]  dly,
    input  logic [NSEG-1:0]  seg_ack,
    input  logic [NCTRL-1:0] ctrlring,
    output logic [NSEG-1:0]  seg_on,
    output logic [NCTRL-1:0] cut_ctrlring,
    output logic             ready,
    output logic             busy,
    output logic             fault
);

    localparam int unsigned     IDXW = clog2_min1(NSEG);
    localparam logic [IDXW-1:0] LAST = IDXW'(NSEG - 1);

    if (NSEG < 1 || TMO < 1) begin : g_bad_param
        $error("asic_iocut_seq: NSEG and TMO must be >= 1");
    end

    state_e           state_q;
    logic [IDXW-1:0]  idx_q, idx_up, idx_dn;
    logic [NSEG-1:0]  seg_on_q;
    logic [NCTRL-1:0] cut_q;
    logic             ready_q, busy_q, fault_q;
    logic             dly_load, dly_zero, tmo_hit;

    assign idx_up = idx_q + IDXW'(1);
    assign idx_dn = idx_q - IDXW'(1);

    // Every step entry reloads the settle counter in the same cycle it moves seg_on.
    always_comb begin
        dly_load = 1'b0;
        unique case (state_q)
            OFF:     dly_load = en;
            UP:      dly_load = !en || (dly_zero && seg_ack[idx_q] && idx_q != LAST);
            ON:      dly_load = !en;
            DOWN:    dly_load = dly_zero && idx_q != '0;
            default: dly_load = 1'b0;
        endcase
    end

    asic_iocut_timer #(.W(DLYW)) u_step (
        .clk   (clk),
        .reset (reset),
        .load  (dly_load),
        .value (dly),
        .zero  (dly_zero)
    );

`ifdef ASIC_IOCUT_SEQ_TIMEOUT_EN
    localparam int unsigned TW = clog2_min1(TMO);
    logic waiting, tmo_zero;

    // Held at TMO-1 until the ack wait begins, so the TMO-th waiting cycle faults.
    assign waiting = (state_q == UP) && dly_zero && !seg_ack[idx_q];
    assign tmo_hit = waiting && tmo_zero;

    asic_iocut_timer #(.W(TW)) u_tmo (
        .clk   (clk),
        .reset (reset),
        .load  (!waiting),
        .value (TW'(TMO - 1)),
        .zero  (tmo_zero)
    );
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= OFF;
            idx_q    <= '0;
            seg_on_q <= '0;
            cut_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            cut_q <= ready_q ? ctrlring : '0;
            unique case (state_q)
                OFF: begin
                    if (en) begin
                        state_q     <= UP;
                        idx_q       <= '0;
                        seg_on_q[0] <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                UP: begin
                    if (!en) begin
                        state_q         <= DOWN;
                        seg_on_q[idx_q] <= 1'b0;
                    end else if (tmo_hit) begin
                        state_q  <= FAULT;
                        idx_q    <= '0;
                        seg_on_q <= '0;
                        busy_q   <= 1'b0;
                        fault_q  <= 1'b1;
                    end else if (dly_zero && seg_ack[idx_q]) begin
                        if (idx_q == LAST) begin
                            state_q <= ON;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q            <= idx_up;
                            seg_on_q[idx_up] <= 1'b1;
                        end
                    end
                end
                ON: begin
                    if (!en) begin
                        state_q        <= DOWN;
                        idx_q          <= LAST;
                        seg_on_q[LAST] <= 1'b0;
                        ready_q        <= 1'b0;
                        busy_q         <= 1'b1;
                        cut_q          <= '0;
                    end
                end
                DOWN: begin
                    if (dly_zero) begin
                        if (idx_q == '0) begin
                            state_q <= OFF;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q            <= idx_dn;
                            seg_on_q[idx_dn] <= 1'b0;
                        end
                    end
                end
                FAULT: begin
                    if (!en) begin
                        state_q <= OFF;
                        fault_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= OFF;
                    idx_q    <= '0;
                    seg_on_q <= '0;
                    ready_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    fault_q  <= 1'b0;
                end
            endcase
        end
    end

    assign seg_on       = seg_on_q;
    assign cut_ctrlring = cut_q;
    assign ready        = ready_q;
    assign busy         = busy_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_asic_iocut_seq.sv
// Scoreboard bench for asic_iocut_seq: expectations are queued per cycle at stimulus time.
module tb_asic_iocut_seq;

    localparam int unsigned NSEG  = 4;
    localparam int unsigned NCTRL = 8;
    localparam int unsigned DLYW  = 8;
`ifdef ASIC_IOCUT_SEQ_TIMEOUT_EN
    localparam int unsigned TB_TMO = 30;
`else
    localparam int unsigned TB_TMO = 255;
`endif

    localparam int SEL_SEG  = 0;
    localparam int SEL_RDY  = 1;
    localparam int SEL_BUSY = 2;
    localparam int SEL_FLT  = 3;
    localparam int SEL_CUT  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [DLYW-1:0]  dly;
    logic [NSEG-1:0]  seg_ack;
    logic [NCTRL-1:0] ctrlring;
    logic [NSEG-1:0]  seg_on;
    logic [NCTRL-1:0] cut_ctrlring;
    logic             ready, busy, fault;

    typedef struct {
        int unsigned cyc;
        int          sel;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    asic_iocut_seq #(.NSEG(NSEG), .NCTRL(NCTRL), .DLYW(DLYW), .TMO(TB_TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .dly          (dly),
        .seg_ack      (seg_ack),
        .ctrlring     (ctrlring),
        .seg_on       (seg_on),
        .cut_ctrlring (cut_ctrlring),
        .ready        (ready),
        .busy         (busy),
        .fault        (fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic exp_at(input int unsigned c, input int sel, input logic [31:0] v, input string tag);
        exp_t e;
        int   pos;
        e.cyc = c;
        e.sel = sel;
        e.val = v;
        e.tag = tag;
        pos = exp_q.size();
        while (pos > 0 && exp_q[pos-1].cyc > c) pos--;
        exp_q.insert(pos, e);
    endtask

    task automatic exp_idle(input int unsigned c, input string tag);
        exp_at(c, SEL_SEG,  0, {tag, "_seg"});
        exp_at(c, SEL_RDY,  0, {tag, "_rdy"});
        exp_at(c, SEL_BUSY, 0, {tag, "_busy"});
        exp_at(c, SEL_FLT,  0, {tag, "_flt"});
        exp_at(c, SEL_CUT,  0, {tag, "_cut"});
    endtask

    task automatic wait_to(input int unsigned c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            case (e.sel)
                SEL_SEG:  act = 32'(seg_on);
                SEL_RDY:  act = 32'(ready);
                SEL_BUSY: act = 32'(busy);
                SEL_FLT:  act = 32'(fault);
                SEL_CUT:  act = 32'(cut_ctrlring);
                default:  act = 'x;
            endcase
            if (e.cyc != cyc) check({e.tag, "_late"}, cyc, e.cyc);
            else              check($sformatf("%s@%0d", e.tag, e.cyc), act, e.val);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned b, t, u;
        reset = 1'b1; en = 1'b0; dly = '0; seg_ack = '0; ctrlring = 8'hA5;

        // reset state
        @(negedge clk);
        b = cyc;
        exp_idle(b + 1, "rst");
        wait_to(b + 1); reset = 1'b0;
        wait_to(b + 3);

        // power-up dly=3, acks high
        b = cyc; dly = 3; seg_ack = 4'hF; en = 1'b1;
        exp_at(b + 1,  SEL_SEG, 4'b0001, "up_s0");
        exp_at(b + 1,  SEL_BUSY, 1, "up_busy1");
        exp_at(b + 4,  SEL_SEG, 4'b0001, "up_s0h");
        exp_at(b + 5,  SEL_SEG, 4'b0011, "up_s1");
        exp_at(b + 9,  SEL_SEG, 4'b0111, "up_s2");
        exp_at(b + 13, SEL_SEG, 4'b1111, "up_s3");
        exp_at(b + 16, SEL_BUSY, 1, "up_busy16");
        exp_at(b + 16, SEL_RDY, 0, "up_rdy16");
        exp_at(b + 17, SEL_RDY, 1, "up_rdy17");
        exp_at(b + 17, SEL_BUSY, 0, "up_busy17");
        exp_at(b + 17, SEL_CUT, 0, "up_cut17");
        exp_at(b + 18, SEL_CUT, 8'hA5, "up_cut18");
        wait_to(b + 20);
        ctrlring = 8'h3C; seg_ack = 4'b1110;
        exp_at(b + 21, SEL_CUT, 8'h3C, "on_cut");
        exp_at(b + 24, SEL_RDY, 1, "on_ackdrop");
        exp_at(b + 24, SEL_SEG, 4'hF, "on_seg");
        wait_to(b + 25); seg_ack = 4'hF;

        // power-down dly=3
        t = cyc; en = 1'b0;
        exp_at(t + 1,  SEL_RDY, 0, "dn_rdy");
        exp_at(t + 1,  SEL_CUT, 0, "dn_cut");
        exp_at(t + 1,  SEL_SEG, 4'b0111, "dn_s3");
        exp_at(t + 1,  SEL_BUSY, 1, "dn_busy1");
        exp_at(t + 5,  SEL_SEG, 4'b0011, "dn_s2");
        exp_at(t + 9,  SEL_SEG, 4'b0001, "dn_s1");
        exp_at(t + 13, SEL_SEG, 4'b0000, "dn_s0");
        exp_at(t + 16, SEL_BUSY, 1, "dn_busy16");
        exp_at(t + 17, SEL_BUSY, 0, "dn_busy17");
        wait_to(t + 20);

        // ack stall on segment 2 for 20 cycles
        b = cyc; dly = 3; seg_ack = 4'b1011; en = 1'b1;
        exp_at(b + 9,  SEL_SEG, 4'b0111, "st_s2");
        exp_at(b + 15, SEL_SEG, 4'b0111, "st_hold15");
        exp_at(b + 20, SEL_SEG, 4'b0111, "st_hold20");
        exp_at(b + 20, SEL_FLT, 0, "st_flt");
        wait_to(b + 20); seg_ack = 4'hF;
        exp_at(b + 21, SEL_SEG, 4'b1111, "st_s3");
        exp_at(b + 24, SEL_RDY, 0, "st_rdy24");
        exp_at(b + 25, SEL_RDY, 1, "st_rdy25");
        wait_to(b + 27); en = 1'b0;
        exp_at(b + 47, SEL_SEG, 0, "st_off_seg");
        exp_at(b + 47, SEL_BUSY, 0, "st_off_busy");
        wait_to(b + 48);

        // abort during UP at seg_on=0011, dly=2
        b = cyc; dly = 2; en = 1'b1;
        exp_at(b + 1, SEL_SEG, 4'b0001, "ab_s0");
        exp_at(b + 4, SEL_SEG, 4'b0011, "ab_s1");
        exp_at(b + 5, SEL_SEG, 4'b0011, "ab_s1h");
        wait_to(b + 5); en = 1'b0;
        exp_at(b + 6,  SEL_SEG, 4'b0001, "ab_c1");
        exp_at(b + 7,  SEL_SEG, 4'b0001, "ab_no2_7");
        exp_at(b + 8,  SEL_SEG, 4'b0001, "ab_no2_8");
        exp_at(b + 8,  SEL_RDY, 0, "ab_rdy");
        exp_at(b + 9,  SEL_SEG, 4'b0000, "ab_c0");
        exp_at(b + 11, SEL_BUSY, 1, "ab_busy11");
        exp_at(b + 12, SEL_BUSY, 0, "ab_busy12");
        wait_to(b + 14);

        // dly=0 power-up, en=1 during DOWN, reset mid-DOWN
        b = cyc; dly = 0; en = 1'b1;
        exp_at(b + 1, SEL_SEG, 4'b0001, "z_s0");
        exp_at(b + 2, SEL_SEG, 4'b0011, "z_s1");
        exp_at(b + 3, SEL_SEG, 4'b0111, "z_s2");
        exp_at(b + 4, SEL_SEG, 4'b1111, "z_s3");
        exp_at(b + 4, SEL_RDY, 0, "z_rdy4");
        exp_at(b + 5, SEL_RDY, 1, "z_rdy5");
        exp_at(b + 5, SEL_BUSY, 0, "z_busy5");
        wait_to(b + 7);
        t = cyc; en = 1'b0;
        exp_at(t + 1, SEL_SEG, 4'b0111, "rv_d3");
        exp_at(t + 2, SEL_SEG, 4'b0011, "rv_d2");
        wait_to(t + 2); en = 1'b1;
        exp_at(t + 3, SEL_SEG, 4'b0001, "rv_d1");
        exp_at(t + 4, SEL_SEG, 4'b0000, "rv_d0");
        exp_at(t + 5, SEL_BUSY, 0, "rv_off");
        exp_at(t + 6, SEL_SEG, 4'b0001, "rv_up0");
        exp_at(t + 6, SEL_BUSY, 1, "rv_busy");
        exp_at(t + 9, SEL_SEG, 4'b1111, "rv_up3");
        exp_at(t + 10, SEL_RDY, 1, "rv_rdy");
        wait_to(t + 12);
        u = cyc; dly = 3; en = 1'b0;
        exp_at(u + 1, SEL_SEG, 4'b0111, "rd_d3");
        exp_at(u + 1, SEL_BUSY, 1, "rd_busy");
        wait_to(u + 3); reset = 1'b1;
        exp_idle(u + 4, "rd_rst");
        wait_to(u + 4); reset = 1'b0;
        exp_at(u + 6, SEL_SEG, 0, "rd_seg");
        exp_at(u + 6, SEL_BUSY, 0, "rd_busy2");
        wait_to(u + 7);

`ifdef ASIC_IOCUT_SEQ_TIMEOUT_EN
        // ack timeout on segment 1
        b = cyc; dly = 3; seg_ack = 4'b1101; en = 1'b1;
        exp_at(b + 5, SEL_SEG, 4'b0011, "to_s1");
        exp_at(b + 8 + TB_TMO - 1, SEL_SEG, 4'b0011, "to_pre_seg");
        exp_at(b + 8 + TB_TMO - 1, SEL_FLT, 0, "to_pre_flt");
        exp_at(b + 8 + TB_TMO, SEL_SEG, 0, "to_seg");
        exp_at(b + 8 + TB_TMO, SEL_FLT, 1, "to_flt");
        exp_at(b + 8 + TB_TMO, SEL_BUSY, 0, "to_busy");
        wait_to(b + 8 + TB_TMO + 3);
        t = cyc;
        exp_at(t + 1, SEL_FLT, 1, "to_hold");
        wait_to(t + 1); en = 1'b0;
        exp_at(t + 2, SEL_FLT, 0, "to_clr");
        exp_at(t + 2, SEL_SEG, 0, "to_clr_seg");
        wait_to(t + 4); seg_ack = 4'hF;
`endif

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
